// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code position tracker.
package gray_pkg;

    // Default code width and the widest code the decoder helper handles.
    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned MAX_WIDTH = 8;

    // Tracker lock state.
    typedef enum logic {
        UNLOCKED,
        TRACKING
    } state_t;

    // Classification of the change between consecutive decoded samples.
    typedef enum logic [1:0] {
        HOLD,
        UP,
        DN,
        JUMP
    } delta_t;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it,
    // which is the XOR of the code with every right shift of itself.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g,
                                                      input int unsigned w);
        logic [MAX_WIDTH-1:0] gm;
        logic [MAX_WIDTH-1:0] b;
        gm = g & MAX_WIDTH'((1 << w) - 1);
        b  = gm;
        for (int unsigned s = 1; s < MAX_WIDTH; s++) begin
            b = b ^ (gm >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational WIDTH-bit Gray to binary decoder.
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    logic [MAX_WIDTH-1:0] w_full;

    // Decode through the shared helper, zero-extended to the helper width.
    always_comb begin
        w_full = gray2bin(MAX_WIDTH'(i_gray), WIDTH);
        o_bin  = w_full[WIDTH-1:0];
    end

endmodule

// File: rtl/gray_step_tracker.sv
// Gray-coded position consumer: decodes each valid sample, classifies the step
// from the previous sample and keeps a saturating position and error count.
module gray_step_tracker
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned POS_W = 16,
    parameter int unsigned ERR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        gray_in,
    input  logic                    clear,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        bin_out,
    output logic                    step_up,
    output logic                    step_dn,
    output logic                    err_jump,
    output logic signed [POS_W-1:0] position,
    output logic [ERR_W-1:0]        err_count,
    output logic                    locked
);

    localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic [WIDTH-1:0] DELTA_DN = '1;

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_delta;
    delta_t           w_class;

    state_t           r_state,     w_state_nxt;
    logic [WIDTH-1:0] r_prev_bin,  w_prev_nxt;
    logic             r_out_valid, w_valid_nxt;
    logic [WIDTH-1:0] r_bin,       w_bin_nxt;
    logic             r_up,        w_up_nxt;
    logic             r_dn,        w_dn_nxt;
    logic             r_jump,      w_jump_nxt;
    logic [POS_W-1:0] r_pos,       w_pos_nxt;
    logic [ERR_W-1:0] r_err,       w_err_nxt;
    logic             r_locked,    w_locked_nxt;

    gray_to_binary #(.WIDTH(WIDTH)) u_dec (
        .i_gray (gray_in),
        .o_bin  (w_bin)
    );

    // Classify the modular difference from the previous accepted sample.
    always_comb begin
        w_delta = w_bin - r_prev_bin;
        if (w_delta == '0)
            w_class = HOLD;
        else if (w_delta == WIDTH'(1))
            w_class = UP;
        else if (w_delta == DELTA_DN)
            w_class = DN;
        else
            w_class = JUMP;
    end

    // Next-state and next-output logic; clear has priority over a sample.
    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev_bin;
        w_valid_nxt  = 1'b0;
        w_bin_nxt    = r_bin;
        w_up_nxt     = 1'b0;
        w_dn_nxt     = 1'b0;
        w_jump_nxt   = 1'b0;
        w_pos_nxt    = r_pos;
        w_err_nxt    = r_err;
        w_locked_nxt = r_locked;
        if (clear) begin
            w_state_nxt  = UNLOCKED;
            w_prev_nxt   = '0;
            w_bin_nxt    = '0;
            w_pos_nxt    = '0;
            w_err_nxt    = '0;
            w_locked_nxt = 1'b0;
        end else if (in_valid) begin
            w_valid_nxt = 1'b1;
            w_bin_nxt   = w_bin;
            w_prev_nxt  = w_bin;
            case (r_state)
                UNLOCKED: begin
                    w_locked_nxt = 1'b1;
                    w_state_nxt  = TRACKING;
                end
                TRACKING: begin
                    case (w_class)
                        UP: begin
                            w_up_nxt = 1'b1;
                            if (r_pos != POS_MAX) w_pos_nxt = r_pos + 1'b1;
                        end
                        DN: begin
                            w_dn_nxt = 1'b1;
                            if (r_pos != POS_MIN) w_pos_nxt = r_pos - 1'b1;
                        end
                        JUMP: begin
                            w_jump_nxt = 1'b1;
                            if (r_err != '1) w_err_nxt = r_err + 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: w_state_nxt = UNLOCKED;
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= UNLOCKED;
            r_prev_bin  <= '0;
            r_out_valid <= 1'b0;
            r_bin       <= '0;
            r_up        <= 1'b0;
            r_dn        <= 1'b0;
            r_jump      <= 1'b0;
            r_pos       <= '0;
            r_err       <= '0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_bin  <= w_prev_nxt;
            r_out_valid <= w_valid_nxt;
            r_bin       <= w_bin_nxt;
            r_up        <= w_up_nxt;
            r_dn        <= w_dn_nxt;
            r_jump      <= w_jump_nxt;
            r_pos       <= w_pos_nxt;
            r_err       <= w_err_nxt;
            r_locked    <= w_locked_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign bin_out   = r_bin;
    assign step_up   = r_up;
    assign step_dn   = r_dn;
    assign err_jump  = r_jump;
    assign position  = r_pos;
    assign err_count = r_err;
    assign locked    = r_locked;

endmodule

// File: tb/tb_gray_step_tracker.sv
// Directed scoreboard bench for gray_step_tracker (POS_W reduced to 4 so the
// position limits are reachable).
module tb_gray_step_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] gray_in = '0;

    logic              out_valid;
    logic [3:0]        bin_out;
    logic              step_up;
    logic              step_dn;
    logic              err_jump;
    logic signed [3:0] position;
    logic [7:0]        err_count;
    logic              locked;
    logic [3:0]        ref_bin;

    typedef struct {
        logic       v;
        logic [3:0] bin;
        logic       up;
        logic       dn;
        logic       jump;
        logic [3:0] pos;
        logic [7:0] err;
        logic       lk;
    } exp_t;

    exp_t sb[$];

    int         m_pos;
    logic [3:0] m_bin;
    logic [3:0] m_prev;
    logic [7:0] m_err;
    logic       m_lk;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gray_step_tracker #(.WIDTH(4), .POS_W(4), .ERR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .gray_in   (gray_in),
        .clear     (clear),
        .out_valid (out_valid),
        .bin_out   (bin_out),
        .step_up   (step_up),
        .step_dn   (step_dn),
        .err_jump  (err_jump),
        .position  (position),
        .err_count (err_count),
        .locked    (locked)
    );

    gray_to_binary #(.WIDTH(4)) u_ref (
        .i_gray (gray_in),
        .o_bin  (ref_bin)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_bin  = '0;
        m_prev = '0;
        m_err  = '0;
        m_lk   = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".bin_out"},   32'(bin_out),   32'd0);
        check({tag, ".pulses"},    32'({step_up, step_dn, err_jump}), 32'd0);
        check({tag, ".position"},  {28'd0, position}, 32'd0);
        check({tag, ".err_count"}, 32'(err_count), 32'd0);
        check({tag, ".locked"},    32'(locked),    32'd0);
    endtask

    // Drive one cycle of stimulus, predict the result, then compare a cycle later.
    task automatic step(input logic v, input logic [3:0] g, input logic c);
        exp_t       e;
        logic [3:0] d;
        @(negedge clk);
        in_valid = v;
        gray_in  = g;
        clear    = c;
        #1;
        e.v = 1'b0; e.up = 1'b0; e.dn = 1'b0; e.jump = 1'b0;
        if (c) begin
            model_reset();
        end else if (v) begin
            e.v = 1'b1;
            if (m_lk) begin
                d = ref_bin - m_prev;
                if (d == 4'd1) begin
                    e.up = 1'b1;
                    if (m_pos < 7) m_pos++;
                end else if (d == 4'hF) begin
                    e.dn = 1'b1;
                    if (m_pos > -8) m_pos--;
                end else if (d != 4'd0) begin
                    e.jump = 1'b1;
                    if (m_err != 8'hFF) m_err++;
                end
            end
            m_lk   = 1'b1;
            m_prev = ref_bin;
            m_bin  = ref_bin;
        end
        e.bin = m_bin;
        e.pos = 4'(m_pos);
        e.err = m_err;
        e.lk  = m_lk;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("out_valid", 32'(out_valid), 32'(e.v));
        check("bin_out",   32'(bin_out),   32'(e.bin));
        check("step_up",   32'(step_up),   32'(e.up));
        check("step_dn",   32'(step_dn),   32'(e.dn));
        check("err_jump",  32'(err_jump),  32'(e.jump));
        check("position",  {28'd0, position}, {28'd0, e.pos});
        check("err_count", 32'(err_count), 32'(e.err));
        check("locked",    32'(locked),    32'(e.lk));
    endtask

    initial begin
        logic [3:0] b;
        model_reset();
        #2;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First sample captures the reference.
        step(1'b1, 4'b0000, 1'b0);
        // Counting up 0..3.
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0011, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        // Idle cycle holds everything.
        step(1'b0, 4'b1111, 1'b0);
        // 3 -> 15 jump, then wrap 15 -> 0 up and 0 -> 15 down.
        step(1'b1, 4'b1000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1000, 1'b0);
        // 15 -> 1 jump, 1 -> 4 jump, 4 -> 5 up.
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0110, 1'b0);
        step(1'b1, 4'b0111, 1'b0);
        // Nine up steps drive the position into the positive limit.
        for (int i = 0; i < 9; i++) begin
            b = 4'(6 + i);
            step(1'b1, b ^ (b >> 1), 1'b0);
        end
        // Twenty down steps drive it into the negative limit.
        for (int i = 0; i < 20; i++) begin
            b = 4'(13 - i);
            step(1'b1, b ^ (b >> 1), 1'b0);
        end
        // Clear together with a sample: sample discarded.
        step(1'b1, 4'b0101, 1'b1);
        step(1'b1, 4'b0000, 1'b0);
        // 300 jumps of 8 saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, (i % 2 == 0) ? 4'b1100 : 4'b0000, 1'b0);
        end
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0011, 1'b0);
        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'b0011, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b0, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
